fp32_to_int32: RTL

FP32_TO_INT32 -- requirements
Module: fp32_to_int32

---
 rtl/fp32_to_int32.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fp32_to_int32.sv
// IEEE 754 single-precision to signed 32-bit integer converter, truncating toward zero.
// Special and out-of-range operands finish in one cycle; others use a one-bit-per-cycle shifter.
module fp32_to_int32 #(
    parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_inexact
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 5;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;

    // Biased exponents of e = 0, e = 23 and e = 31
    localparam logic [EXP_W-1:0] EXP_E0  = 8'd127;
    localparam logic [EXP_W-1:0] EXP_E23 = 8'd150;
    localparam logic [EXP_W-1:0] EXP_E31 = 8'd158;
    localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [DATA_W-1:0] INT_MAX = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_d;
    logic [DATA_W-1:0]    mag, mag_d;
    logic [COUNT_W-1:0]   count, count_d;
    logic                 dir_left, dir_left_d;
    logic                 sticky, sticky_d;
    logic                 sign, sign_d;
    logic [DATA_W-1:0]    out_data_d;
    logic                 out_invalid_d, out_inexact_d;

    logic [EXP_W-1:0]     exp_f;
    logic [FRAC_W-1:0]    frac_f;

    assign exp_f     = in_data[30:23];
    assign frac_f    = in_data[22:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Next-state and datapath update
    always_comb begin
        state_d       = state;
        mag_d         = mag;
        count_d       = count;
        dir_left_d    = dir_left;
        sticky_d      = sticky;
        sign_d        = sign;
        out_data_d    = out_data;
        out_invalid_d = out_invalid;
        out_inexact_d = out_inexact;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_d        = in_data[31];
                    out_invalid_d = 1'b0;
                    out_inexact_d = 1'b0;
                    state_d       = DONE;
                    if (exp_f == '0) begin
                        out_data_d    = '0;
                        out_inexact_d = (frac_f != '0);
                    end else if (exp_f == '1 && frac_f != '0) begin
                        out_data_d    = NAN_RESULT;
                        out_invalid_d = 1'b1;
                    end else if (in_data == 32'hCF00_0000) begin
                        out_data_d = INT_MIN;
                    end else if (exp_f >= EXP_E31) begin
                        // Infinity or magnitude beyond the int32 range saturates by sign
                        out_data_d    = in_data[31] ? INT_MIN : INT_MAX;
                        out_invalid_d = 1'b1;
                    end else if (exp_f < EXP_E0) begin
                        out_data_d    = '0;
                        out_inexact_d = 1'b1;
                    end else begin
                        mag_d      = {8'b0, 1'b1, frac_f};
                        dir_left_d = (exp_f >= EXP_E23);
                        count_d    = (exp_f >= EXP_E23) ? COUNT_W'(exp_f - EXP_E23)
                                                        : COUNT_W'(EXP_E23 - exp_f);
                        sticky_d   = 1'b0;
                        state_d    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (count != '0) begin
                    count_d = count - COUNT_W'(1);
                    if (dir_left) begin
                        mag_d = {mag[DATA_W-2:0], 1'b0};
                    end else begin
                        mag_d    = {1'b0, mag[DATA_W-1:1]};
                        sticky_d = sticky | mag[0];
                    end
                end else begin
                    out_data_d    = sign ? (DATA_W'(0) - mag) : mag;
                    out_inexact_d = sticky;
                    out_invalid_d = 1'b0;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mag         <= '0;
            count       <= '0;
            dir_left    <= 1'b0;
            sticky      <= 1'b0;
            sign        <= 1'b0;
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            state       <= state_d;
            mag         <= mag_d;
            count       <= count_d;
            dir_left    <= dir_left_d;
            sticky      <= sticky_d;
            sign        <= sign_d;
            out_data    <= out_data_d;
            out_invalid <= out_invalid_d;
            out_inexact <= out_inexact_d;
        end
    end
endmodule
